// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - GW5AST PLL reset/lock/divider sequencer; phase stepping under PLL_PHASE_STEP_EN
module pll_reconfig_ctrl #(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MDIV_A              = 29,
    parameter int ODIV0_A             = 27,
    parameter int ODIV1_A             = 27,
    parameter int ODIV2_A             = 54,
    parameter int MDIV_B              = 35,
    parameter int ODIV0_B             = 33,
    parameter int ODIV1_B             = 33,
    parameter int ODIV2_B             = 66,
    parameter int PS_PULSE_CYCLES     = 4,
    parameter int PS_GAP_CYCLES       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_sel,
    input  logic       mode_req,
    input  logic       ps_req,
    input  logic [2:0] ps_sel,
    input  logic       ps_dir,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [6:0] pll_mdsel,
    output logic [6:0] pll_odsel0,
    output logic [6:0] pll_odsel1,
    output logic [6:0] pll_odsel2,
    output logic [2:0] pll_pssel,
    output logic       pll_psdir,
    output logic       pll_pspulse,
    output logic       sys_reset,
    output logic       busy,
    output logic       mode_cur,
    output logic [3:0] retry_cnt
);
    localparam int MAX_0   = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_1   = (MAX_0 > LOCK_TIMEOUT_CYCLES) ? MAX_0 : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_2   = (MAX_1 > PS_PULSE_CYCLES) ? MAX_1 : PS_PULSE_CYCLES;
    localparam int CNT_MAX = (MAX_2 > PS_GAP_CYCLES) ? MAX_2 : PS_GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        PRST, WLOCK, STABLE, RUN
`ifdef PLL_PHASE_STEP_EN
        , PSHI, PSLO
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lock_sync;
    logic          lock;

    // pll_lock comes from the PLL's own clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[0], pll_lock};
        end
    end
    assign lock = lock_sync[1];

`ifndef PLL_PHASE_STEP_EN
    logic ps_unused;
    assign ps_unused   = ^{ps_req, ps_sel, ps_dir};
    assign pll_pssel   = '0;
    assign pll_psdir   = 1'b0;
    assign pll_pspulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PRST;
            cnt        <= '0;
            pll_reset  <= 1'b1;
            sys_reset  <= 1'b1;
            busy       <= 1'b1;
            mode_cur   <= 1'b0;
            retry_cnt  <= '0;
            pll_mdsel  <= 7'(MDIV_A);
            pll_odsel0 <= 7'(ODIV0_A);
            pll_odsel1 <= 7'(ODIV1_A);
            pll_odsel2 <= 7'(ODIV2_A);
`ifdef PLL_PHASE_STEP_EN
            pll_pssel   <= '0;
            pll_psdir   <= 1'b0;
            pll_pspulse <= 1'b0;
`endif
        end else begin
            // dividers only move while the PLL is held in reset
            if (state == PRST) begin
                pll_mdsel  <= mode_cur ? 7'(MDIV_B)  : 7'(MDIV_A);
                pll_odsel0 <= mode_cur ? 7'(ODIV0_B) : 7'(ODIV0_A);
                pll_odsel1 <= mode_cur ? 7'(ODIV1_B) : 7'(ODIV1_A);
                pll_odsel2 <= mode_cur ? 7'(ODIV2_B) : 7'(ODIV2_A);
            end
            case (state)
                PRST: begin
                    if (cnt == CW'(RESET_CYCLES - 1)) begin
                        state     <= WLOCK;
                        cnt       <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WLOCK: begin
                    if (lock) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        state     <= PRST;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        if (retry_cnt != 4'hF) retry_cnt <= retry_cnt + 4'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock) begin
                        state <= WLOCK;
                        cnt   <= '0;
                    end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                        state     <= RUN;
                        cnt       <= '0;
                        sys_reset <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock) begin
                        state     <= WLOCK;
                        cnt       <= '0;
                        sys_reset <= 1'b1;
                        busy      <= 1'b1;
                    end else if (mode_req && (mode_sel != mode_cur)) begin
                        state     <= PRST;
                        cnt       <= '0;
                        mode_cur  <= mode_sel;
                        pll_reset <= 1'b1;
                        sys_reset <= 1'b1;
                        busy      <= 1'b1;
`ifdef PLL_PHASE_STEP_EN
                    end else if (ps_req) begin
                        state       <= PSHI;
                        cnt         <= '0;
                        pll_pssel   <= ps_sel;
                        pll_psdir   <= ps_dir;
                        pll_pspulse <= 1'b1;
                        busy        <= 1'b1;
`endif
                    end
                end
`ifdef PLL_PHASE_STEP_EN
                PSHI: begin
                    if (!lock) begin
                        state       <= WLOCK;
                        cnt         <= '0;
                        pll_pspulse <= 1'b0;
                        sys_reset   <= 1'b1;
                    end else if (cnt == CW'(PS_PULSE_CYCLES - 1)) begin
                        state       <= PSLO;
                        cnt         <= '0;
                        pll_pspulse <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PSLO: begin
                    if (!lock) begin
                        state     <= WLOCK;
                        cnt       <= '0;
                        sys_reset <= 1'b1;
                    end else if (cnt == CW'(PS_GAP_CYCLES - 1)) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= PRST;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - event scoreboard bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;
    localparam int STB = 1024;
    localparam int TMO = 700;
    localparam int PER = 16 + TMO;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_sel = 1'b0, mode_req = 1'b0, ps_req = 1'b0, ps_dir = 1'b0, pll_lock = 1'b0;
    logic [2:0] ps_sel = 3'd0;
    logic       pll_reset, pll_psdir, pll_pspulse, sys_reset, busy, mode_cur;
    logic [6:0] pll_mdsel, pll_odsel0, pll_odsel1, pll_odsel2;
    logic [2:0] pll_pssel;
    logic [3:0] retry_cnt;

    pll_reconfig_ctrl #(.LOCK_TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .mode_sel(mode_sel), .mode_req(mode_req),
        .ps_req(ps_req), .ps_sel(ps_sel), .ps_dir(ps_dir), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_mdsel(pll_mdsel), .pll_odsel0(pll_odsel0),
        .pll_odsel1(pll_odsel1), .pll_odsel2(pll_odsel2), .pll_pssel(pll_pssel),
        .pll_psdir(pll_psdir), .pll_pspulse(pll_pspulse), .sys_reset(sys_reset),
        .busy(busy), .mode_cur(mode_cur), .retry_cnt(retry_cnt)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // event kinds: 0 pll_reset, 1 sys_reset, 2 busy, 3 mode_cur, 4 retry_cnt, 5 pll_pspulse
    typedef struct { int cyc; int kind; int val; int aux; } ev_t;
    ev_t expq[$];
    int  checks = 0, errors = 0;
    bit  mon_on = 0, primed = 0;
    int  prv[6];
    int  mode_m = 0;

    function automatic int div_of(int m, int idx);
        int a[4], b[4];
        a = '{29, 27, 27, 54};
        b = '{35, 33, 33, 66};
        return m ? b[idx] : a[idx];
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(int c, int k, int v, int aux = 0);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v; e.aux = aux;
        expq.push_back(e);
    endtask

    task automatic check_divs(string tag, int m);
        check({tag, "_mdsel"},  int'(pll_mdsel),  div_of(m, 0));
        check({tag, "_odsel0"}, int'(pll_odsel0), div_of(m, 1));
        check({tag, "_odsel1"}, int'(pll_odsel1), div_of(m, 2));
        check({tag, "_odsel2"}, int'(pll_odsel2), div_of(m, 3));
    endtask

    task automatic handle(int k, int v);
        ev_t e;
        if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: kind %0d became %0d at cycle %0d, expected nothing", k, v, cyc);
            return;
        end
        e = expq.pop_front();
        check($sformatf("event_kind@%0d", e.cyc), k, e.kind);
        check($sformatf("event_cycle_k%0d", k), cyc, e.cyc);
        check($sformatf("event_value_k%0d", k), v, e.val);
        if (k == 0 && v == 0) check_divs("div_at_release", e.aux);
        if (k == 5 && v == 1) check("ps_sel_dir", int'({pll_pssel, pll_psdir}), e.aux);
    endtask

    always @(negedge clk) begin
        int cur[6];
        cur = '{int'(pll_reset), int'(sys_reset), int'(busy), int'(mode_cur),
                int'(retry_cnt), int'(pll_pspulse)};
        if (mon_on) begin
            if (primed) begin
                for (int k = 0; k < 6; k++)
                    if (cur[k] != prv[k]) handle(k, cur[k]);
            end
            primed = 1;
        end
        prv = cur;
    end

    // return just after edge e; an input set here is sampled at edge e+1
    task automatic step_to(int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mode_switch(int m);
        int q, l3, s;
        q = cyc + $urandom_range(3, 20);
        if (m != mode_m) begin
            expect_ev(q, 0, 1); expect_ev(q, 1, 1); expect_ev(q, 2, 1); expect_ev(q, 3, m);
            mode_m = m;
            expect_ev(q + 16, 0, 0, m);
            l3 = q + $urandom_range(8, 40);
            s  = imax(l3 + 2, q + 17);
            expect_ev(s + STB, 1, 0); expect_ev(s + STB, 2, 0);
            step_to(q - 1); mode_sel = m[0]; mode_req = 1'b1;
            step_to(q);     mode_req = 1'b0; pll_lock = 1'b0;
            step_to(q + 5); mode_sel = ~m[0]; mode_req = 1'b1;
            step_to(q + 6); mode_req = 1'b0;
            step_to(l3 - 1); pll_lock = 1'b1;
            step_to(s + STB + 2);
        end else begin
            step_to(q - 1); mode_sel = m[0]; mode_req = 1'b1;
            step_to(q);     mode_req = 1'b0;
            step_to(q + 30);
        end
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, l, s, d, l2, g, k, n, p, x, y, sel, dir;

        step_to(3);
        check("rst_pll_reset", int'(pll_reset), 1);
        check("rst_sys_reset", int'(sys_reset), 1);
        check("rst_busy", int'(busy), 1);
        check("rst_mode_cur", int'(mode_cur), 0);
        check("rst_retry_cnt", int'(retry_cnt), 0);
        check("rst_pspulse", int'(pll_pspulse), 0);
        check("rst_pssel_psdir", int'({pll_pssel, pll_psdir}), 0);
        check_divs("rst", 0);
        mon_on = 1;
        reset = 1'b0;
        r = cyc;

        // power-up: raw lock rises 30 cycles after reset release
        l = r + 30;
        s = imax(l + 2, r + 17);
        expect_ev(r + 16, 0, 0, 0);
        expect_ev(s + STB, 1, 0); expect_ev(s + STB, 2, 0);
        step_to(l - 1); pll_lock = 1'b1;
        step_to(s + STB + 2);

        // lock loss in RUN coinciding with a mode request, then a glitch during STABLE
        d = cyc + $urandom_range(5, 40);
        expect_ev(d + 2, 1, 1); expect_ev(d + 2, 2, 1);
        l2 = d + 2 + $urandom_range(1, 30);
        s  = l2 + 2;
        k  = $urandom_range(0, 1000);
        n  = $urandom_range(1, 5);
        g  = s - 1 + k;
        expect_ev(g + n + 2 + STB, 1, 0); expect_ev(g + n + 2 + STB, 2, 0);
        step_to(d - 1); pll_lock = 1'b0;
        step_to(d + 1); mode_sel = 1'b1; mode_req = 1'b1;
        step_to(d + 2); mode_req = 1'b0;
        step_to(l2 - 1); pll_lock = 1'b1;
        step_to(g - 1);  pll_lock = 1'b0;
        step_to(g + n - 1); pll_lock = 1'b1;
        step_to(g + n + 2 + STB + 2);

        // mode switching, including repeats of the current mode
        mode_switch(1);
        mode_switch(1);
        for (int i = 0; i < 3; i++) mode_switch($urandom_range(0, 1));
        if (mode_m == 0) mode_switch(1);

`ifdef PLL_PHASE_STEP_EN
        for (int i = 0; i < 3; i++) begin
            sel = (i == 0) ? 1 : $urandom_range(0, 7);
            dir = (i == 0) ? 1 : $urandom_range(0, 1);
            p = cyc + $urandom_range(3, 20);
            expect_ev(p, 2, 1); expect_ev(p, 5, 1, sel * 2 + dir);
            expect_ev(p + 4, 5, 0); expect_ev(p + 12, 2, 0);
            step_to(p - 1); ps_sel = 3'(sel); ps_dir = dir[0]; ps_req = 1'b1;
            step_to(p);     ps_req = 1'b0; ps_sel = ~ps_sel; ps_dir = ~ps_dir;
            step_to(p + 5); ps_req = 1'b1;
            step_to(p + 6); ps_req = 1'b0;
            step_to(p + 15);
            check("ps_latched", int'({pll_pssel, pll_psdir}), sel * 2 + dir);
        end
        // reset while the pulse is high, in mode B
        p = cyc + $urandom_range(3, 20);
        expect_ev(p, 2, 1); expect_ev(p, 5, 1, 2 * 5 + 0);
        expect_ev(p + 2, 0, 1); expect_ev(p + 2, 1, 1); expect_ev(p + 2, 3, 0); expect_ev(p + 2, 5, 0);
        step_to(p - 1); ps_sel = 3'd5; ps_dir = 1'b0; ps_req = 1'b1;
        step_to(p);     ps_req = 1'b0;
        step_to(p + 1); reset = 1'b1; pll_lock = 1'b0;
        step_to(p + 2); reset = 1'b0;
`else
        for (int i = 0; i < 3; i++) begin
            p = cyc + $urandom_range(3, 20);
            step_to(p - 1); ps_sel = 3'($urandom_range(1, 7)); ps_dir = 1'b1; ps_req = 1'b1;
            step_to(p);     ps_req = 1'b0;
            step_to(p + 15);
            check("ps_ignored_sel_dir", int'({pll_pssel, pll_psdir}), 0);
        end
        x = cyc + $urandom_range(3, 10);
        expect_ev(x, 0, 1); expect_ev(x, 1, 1); expect_ev(x, 2, 1); expect_ev(x, 3, 0);
        step_to(x - 1); reset = 1'b1; pll_lock = 1'b0;
        step_to(x);     reset = 1'b0;
`endif
        mode_m = 0;
        r = cyc;
        check("midrst_pspulse", int'(pll_pspulse), 0);
        check("midrst_pll_reset", int'(pll_reset), 1);
        check("midrst_mode_cur", int'(mode_cur), 0);
        check_divs("midrst", 0);

        // lock never arrives: periodic re-reset, retry count saturates at 15
        expect_ev(r + 16, 0, 0, 0);
        for (int i = 1; i <= 17; i++) begin
            expect_ev(r + i * PER, 0, 1);
            if (i <= 15) expect_ev(r + i * PER, 4, i);
            expect_ev(r + i * PER + 16, 0, 0, 0);
        end
        step_to(r + 15 * PER + 20);
        check("retry_saturated", int'(retry_cnt), 15);
        y = r + 17 * PER + 20;
        expect_ev(y, 0, 1); expect_ev(y, 4, 0);
        step_to(y - 1); reset = 1'b1;
        step_to(y);     reset = 1'b0;
        step_to(y + 5);
        check("expected_events_left", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
